// File: rtl/joy_pkg.sv
// Shared definitions for the joystick shift-register scanner: FSM states,
// per-player button bit positions and the frame width.
package joy_pkg;

    localparam int unsigned FrameWidth = 16;

    // Button order within one player's byte of the serial frame.
    localparam int unsigned IdxUp    = 0;
    localparam int unsigned IdxDown  = 1;
    localparam int unsigned IdxLeft  = 2;
    localparam int unsigned IdxRight = 3;
    localparam int unsigned IdxFire1 = 4;
    localparam int unsigned IdxFire2 = 5;
    localparam int unsigned IdxFire3 = 6;
    localparam int unsigned IdxStart = 7;
    localparam int unsigned Joy2Base = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StUpdate
    } joy_state_e;

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running 0..CLKDIV-1 divider producing a one-cycle scan tick on wrap.
// i_clr restarts the count so the update cycle adds exactly one sysclk per frame.
module joy_tick_gen #(
    parameter int unsigned CLKDIV = 14
) (
    input  logic sysclk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CntW = $clog2(CLKDIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKDIV - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge sysclk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == CntMax) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CntMax);

endmodule

// File: rtl/joy_scanner.sv
// Scans two 8-button joysticks through an external parallel-in/serial-out chain.
// Define JOY_SCANNER_DEBOUNCE_EN to accept a frame only when it repeats the previous one.
module joy_scanner
    import joy_pkg::*;
#(
    parameter int unsigned CLKDIV = 14,
    parameter int unsigned GAP    = 64
) (
    input  logic sysclk,
    input  logic reset,
    input  logic joy_data,
    output logic joy_clk,
    output logic joy_load_n,
    output logic joy1up,
    output logic joy1down,
    output logic joy1left,
    output logic joy1right,
    output logic joy1fire1,
    output logic joy1fire2,
    output logic joy1fire3,
    output logic joy1start,
    output logic joy2up,
    output logic joy2down,
    output logic joy2left,
    output logic joy2right,
    output logic joy2fire1,
    output logic joy2fire2,
    output logic joy2fire3,
    output logic joy2start,
    output logic frame_done
);

    localparam logic [9:0] GapMax = 10'(GAP - 1);
    localparam logic [3:0] IdxLast = 4'(FrameWidth - 1);

    joy_state_e r_state, w_state_d;
    logic [9:0] r_gap, w_gap_d;
    logic [3:0] r_idx, w_idx_d;
    logic       r_phase, w_phase_d;
    logic       w_sample;
    logic       w_tick;
    logic       w_upd;
    logic       w_copy;

    logic [FrameWidth-1:0] r_shadow;
    logic [FrameWidth-1:0] r_joy;
    logic                  r_joy_clk;
    logic                  r_load_n;
    logic                  r_frame_done;

    joy_tick_gen #(
        .CLKDIV (CLKDIV)
    ) u_tick_gen (
        .sysclk (sysclk),
        .reset  (reset),
        .i_clr  (r_state == StUpdate),
        .o_tick (w_tick)
    );

    // r_phase: in LOAD marks the second tick, in SHIFT marks the joy_clk high half.
    always_comb begin
        w_state_d = r_state;
        w_gap_d   = r_gap;
        w_idx_d   = r_idx;
        w_phase_d = r_phase;
        w_sample  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_tick) begin
                    if (r_gap == GapMax) begin
                        w_state_d = StLoad;
                        w_gap_d   = '0;
                        w_phase_d = 1'b0;
                    end else begin
                        w_gap_d = r_gap + 10'd1;
                    end
                end
            end
            StLoad: begin
                if (w_tick) begin
                    if (r_phase) begin
                        w_state_d = StShift;
                        w_idx_d   = '0;
                        w_phase_d = 1'b0;
                    end else begin
                        w_phase_d = 1'b1;
                    end
                end
            end
            StShift: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_sample  = 1'b1;
                        w_phase_d = 1'b1;
                    end else if (r_idx == IdxLast) begin
                        w_state_d = StUpdate;
                        w_idx_d   = '0;
                        w_phase_d = 1'b0;
                    end else begin
                        w_idx_d   = r_idx + 4'd1;
                        w_phase_d = 1'b0;
                    end
                end
            end
            StUpdate: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // UPDATE lasts one cycle, so entering it is a single-cycle event.
    assign w_upd = (w_state_d == StUpdate);

`ifdef JOY_SCANNER_DEBOUNCE_EN
    logic [FrameWidth-1:0] r_prev;

    assign w_copy = w_upd && (r_shadow == r_prev);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_prev <= '1;
        end else if (w_upd) begin
            r_prev <= r_shadow;
        end
    end
`else
    assign w_copy = w_upd;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_gap        <= '0;
            r_idx        <= '0;
            r_phase      <= 1'b0;
            r_shadow     <= '1;
            r_joy        <= '1;
            r_joy_clk    <= 1'b0;
            r_load_n     <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_gap        <= w_gap_d;
            r_idx        <= w_idx_d;
            r_phase      <= w_phase_d;
            // Strobes derive from the next state so they align with it and never overlap.
            r_load_n     <= (w_state_d != StLoad);
            r_joy_clk    <= (w_state_d == StShift) && w_phase_d;
            r_frame_done <= w_copy;
            if (w_sample) begin
                r_shadow[r_idx] <= joy_data;
            end
            if (w_copy) begin
                r_joy <= r_shadow;
            end
        end
    end

    assign joy_clk    = r_joy_clk;
    assign joy_load_n = r_load_n;
    assign frame_done = r_frame_done;

    assign joy1up    = r_joy[IdxUp];
    assign joy1down  = r_joy[IdxDown];
    assign joy1left  = r_joy[IdxLeft];
    assign joy1right = r_joy[IdxRight];
    assign joy1fire1 = r_joy[IdxFire1];
    assign joy1fire2 = r_joy[IdxFire2];
    assign joy1fire3 = r_joy[IdxFire3];
    assign joy1start = r_joy[IdxStart];
    assign joy2up    = r_joy[Joy2Base + IdxUp];
    assign joy2down  = r_joy[Joy2Base + IdxDown];
    assign joy2left  = r_joy[Joy2Base + IdxLeft];
    assign joy2right = r_joy[Joy2Base + IdxRight];
    assign joy2fire1 = r_joy[Joy2Base + IdxFire1];
    assign joy2fire2 = r_joy[Joy2Base + IdxFire2];
    assign joy2fire3 = r_joy[Joy2Base + IdxFire3];
    assign joy2start = r_joy[Joy2Base + IdxStart];

endmodule

// File: doc/joy_scanner.md
JOY_SCANNER -- requirements
Module: joy_scanner

Interface
REQ-001 Parameter CLKDIV, default 14, means sysclk cycles per scan tick (28 MHz / 14 gives 2 MHz ticks and a 1 MHz joy_clk); legal range 2..255.
REQ-002 Parameter GAP, default 64, means idle ticks between scan frames; legal range 1..1023.
REQ-003 Port: sysclk, input, 1, sole clock; all logic SHALL be on its rising edge.
REQ-004 Port: reset, input, 1, synchronous active-high reset.
REQ-005 Port: joy_data, input, 1, serial data from the external shift-register chain.
REQ-006 Port: joy_clk, output, 1, shift clock to the chain.
REQ-007 Port: joy_load_n, output, 1, parallel-load strobe to the chain, active low.
REQ-008 Ports: joy1up, joy1down, joy1left, joy1right, joy1fire1, joy1fire2, joy1fire3, joy1start; outputs, 1 bit each; active low (0 = pressed).
REQ-009 Ports: joy2up, joy2down, joy2left, joy2right, joy2fire1, joy2fire2, joy2fire3, joy2start; outputs, 1 bit each; active low.
REQ-010 Port: frame_done, output, 1, one-cycle strobe marking an output update.

Function
REQ-011 A tick counter SHALL count 0..CLKDIV-1 and assert tick for one sysclk cycle on wrap; it runs in every state.
REQ-012 FSM states are IDLE, LOAD, SHIFT and UPDATE; all transitions SHALL occur only on tick, except UPDATE.
REQ-013 IDLE: joy_load_n=1 and joy_clk=0; after GAP ticks go to LOAD.
REQ-014 LOAD: joy_load_n=0 for exactly 2 ticks with joy_clk=0; then go to SHIFT with bit index 0.
REQ-015 SHIFT: each bit spans 2 ticks (joy_clk low tick, then joy_clk high tick).
REQ-016 SHIFT sampling: joy_data SHALL be sampled into shadow[index] on the tick that ends the low phase, i.e. before the rising joy_clk.
REQ-017 SHIFT exit: after index 15 completes its high phase, joy_clk returns to 0 and the FSM goes to UPDATE.
REQ-018 Bit mapping, index 0..7 = joy1 up, down, left, right, fire1, fire2, fire3, start; index 8..15 = the same order for joy2.
REQ-019 Polarity: the chain delivers 0 = pressed, and the bits SHALL be passed through uninverted.
REQ-020 UPDATE lasts one sysclk cycle: outputs <= shadow (subject to REQ-027) and frame_done=1; next state IDLE.
REQ-021 Outputs SHALL change only in UPDATE, never mid-frame.
REQ-022 Frame length SHALL be exactly (2 + 32 + GAP) ticks plus 1 sysclk cycle.
REQ-023 joy_clk and joy_load_n SHALL be registered outputs (glitch-free), and SHALL never be simultaneously active.
REQ-024 The bit index SHALL be 4 bits wide and the gap counter 10 bits wide; neither SHALL wrap inside a state.

Reset
REQ-025 While reset=1: state=IDLE; tick, gap and index counters=0; joy_clk=0; joy_load_n=1; all joy outputs=1; frame_done=0; shadow=16'hFFFF.
REQ-026 Reset asserted mid-LOAD or mid-SHIFT SHALL abort the frame, and the first post-reset frame SHALL begin after a full GAP.

Configuration
REQ-027 Macro JOY_SCANNER_DEBOUNCE_EN defined: UPDATE copies shadow to the outputs only when shadow equals the previous frame's shadow, and frame_done pulses only on an actual copy; a 16-bit previous-frame register is added and reset to 16'hFFFF.
REQ-028 Macro JOY_SCANNER_DEBOUNCE_EN undefined: every UPDATE copies shadow, frame_done pulses every frame, and no previous-frame register exists.

Structure
REQ-029 The shared package joy_pkg SHALL hold the FSM state enum, the bit-index constants from REQ-018, and the frame width constant 16.
REQ-030 A sub-module joy_tick_gen SHALL contain the CLKDIV tick counter; all other logic stays flat in joy_scanner.

Verification
REQ-031 Reset scenario: hold reset for 5 cycles -> all joy outputs=1, joy_load_n=1, joy_clk=0, frame_done=0.
REQ-032 Frame timing scenario: with CLKDIV=14 and GAP=64 -> joy_load_n low for 28 cycles, 16 rising joy_clk edges 28 cycles apart, frame_done period 1373 cycles.
REQ-033 Mapping scenario: chain model returns 16'hFFFE then 16'h7FFF -> first joy1up=0 with all others 1, then joy2start=0 with all others 1.
REQ-034 Abort scenario: assert reset during bit 7 of SHIFT -> outputs remain at the prior frame value (1s after reset), and the next joy_load_n falling edge occurs exactly 64 ticks after reset release.
REQ-035 Debounce scenario (macro defined): pattern A for 1 frame, then B for 2 frames -> outputs ignore A (single frame) and take B at the second B frame's UPDATE; without the macro, outputs follow A then B immediately.
REQ-036 Invariant check: joy_clk=1 and joy_load_n=0 never occur in the same cycle.
